// File: rtl/text_lcd_ctrl.sv
// HD44780-style character LCD controller: power-up init once, then continuous refresh
// of the panel from an internal character buffer written through a simple write port.
module text_lcd_ctrl #(
    parameter int COLS      = 16,
    parameter int LINES     = 2,
    parameter int AW        = 6,
    parameter int PWR_CYC   = 70,
    parameter int SETUP_CYC = 1,
    parameter int EHIGH_CYC = 2,
    parameter int CMD_CYC   = 30,
    parameter int CLR_CYC   = 200,
    parameter int CHAR_CYC  = 4,
    parameter int GAP_CYC   = 400
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          cursor_on,
    input  logic          blink_on,
    output logic          lcd_e,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic [7:0]    lcd_data,
    output logic          init_done,
    output logic          frame_pulse
);

    localparam int NCHAR = COLS * LINES;
    localparam logic [31:0] NCHAR_U = NCHAR;
    localparam int M1 = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
    localparam int M2 = (M1 > GAP_CYC) ? M1 : GAP_CYC;
    localparam int M3 = (M2 > CMD_CYC) ? M2 : CMD_CYC;
    localparam int M4 = (M3 > CHAR_CYC) ? M3 : CHAR_CYC;
    localparam int M5 = (M4 > SETUP_CYC) ? M4 : SETUP_CYC;
    localparam int MAXC = (M5 > EHIGH_CYC) ? M5 : EHIGH_CYC;
    localparam int CW = $clog2(MAXC + 1);
    localparam int COLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int LINEW = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [CW-1:0] PWR_L   = CW'(PWR_CYC - 1);
    localparam logic [CW-1:0] GAP_L   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] SETUP_L = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EHI_L   = CW'(EHIGH_CYC - 1);
    localparam logic [CW-1:0] CMD_L   = CW'(CMD_CYC - 1);
    localparam logic [CW-1:0] CLR_L   = CW'(CLR_CYC - 1);
    localparam logic [CW-1:0] CHAR_L  = CW'(CHAR_CYC - 1);
    localparam logic [COLW-1:0]  COL_LAST  = COLW'(COLS - 1);
    localparam logic [LINEW-1:0] LINE_LAST = LINEW'(LINES - 1);

    typedef enum logic [2:0] {
        S_PWR, S_FSET, S_DISP, S_ENTRY, S_CLR, S_ADDR, S_CHAR, S_GAP
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_EHI, PH_WAIT} phase_t;

    state_t           state, state_n, go_st;
    phase_t           phase, phase_n;
    logic [CW-1:0]    cnt, cnt_n, wlim;
    logic [COLW-1:0]  col, col_n;
    logic [LINEW-1:0] line, line_n;
    logic             e_n, rs_n, init_n, fp_n, go;
    logic [7:0]       data_n, base_n, char_n;
    logic [AW-1:0]    rd_idx;
    logic [7:0]       char_mem [2**AW];

    assign lcd_rw = 1'b0;

    // Writes land on the same edge a CHAR transaction samples the buffer, so that read sees the old value.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < 2**AW; i++) char_mem[i] <= 8'h20;
        end else if (wr_en && (32'(wr_addr) < NCHAR_U)) begin
            char_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state       <= S_PWR;
            phase       <= PH_SETUP;
            cnt         <= '0;
            col         <= '0;
            line        <= '0;
            lcd_e       <= 1'b0;
            lcd_rs      <= 1'b0;
            lcd_data    <= 8'h00;
            init_done   <= 1'b0;
            frame_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            cnt         <= cnt_n;
            col         <= col_n;
            line        <= line_n;
            lcd_e       <= e_n;
            lcd_rs      <= rs_n;
            lcd_data    <= data_n;
            init_done   <= init_n;
            frame_pulse <= fp_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        cnt_n   = cnt + 1'b1;
        col_n   = col;
        line_n  = line;
        e_n     = lcd_e;
        rs_n    = lcd_rs;
        data_n  = lcd_data;
        init_n  = init_done;
        fp_n    = 1'b0;
        go      = 1'b0;
        go_st   = state;
        rd_idx  = '0;
        base_n  = 8'h00;
        char_n  = 8'h20;

        case (state)
            S_CLR:   wlim = CLR_L;
            S_CHAR:  wlim = CHAR_L;
            default: wlim = CMD_L;
        endcase

        case (state)
            S_PWR: begin
                if (cnt == PWR_L) begin
                    go    = 1'b1;
                    go_st = S_FSET;
                end
            end
            S_GAP: begin
                if (cnt == GAP_L) begin
                    go    = 1'b1;
                    go_st = S_ADDR;
                end
            end
            default: begin
                case (phase)
                    PH_SETUP: begin
                        if (cnt == SETUP_L) begin
                            phase_n = PH_EHI;
                            cnt_n   = '0;
                            e_n     = 1'b1;
                        end
                    end
                    PH_EHI: begin
                        if (cnt == EHI_L) begin
                            phase_n = PH_WAIT;
                            cnt_n   = '0;
                            e_n     = 1'b0;
                        end
                    end
                    default: begin
                        if (cnt == wlim) begin
                            go = 1'b1;
                            case (state)
                                S_FSET:  go_st = S_DISP;
                                S_DISP:  go_st = S_ENTRY;
                                S_ENTRY: go_st = S_CLR;
                                S_CLR: begin
                                    go_st  = S_ADDR;
                                    line_n = '0;
                                    col_n  = '0;
                                    init_n = 1'b1;
                                end
                                S_ADDR: begin
                                    go_st = S_CHAR;
                                    col_n = '0;
                                end
                                default: begin
                                    if (col == COL_LAST) begin
                                        col_n = '0;
                                        if (line == LINE_LAST) begin
                                            line_n = '0;
                                            go_st  = S_GAP;
                                        end else begin
                                            line_n = line + 1'b1;
                                            go_st  = S_ADDR;
                                        end
                                    end else begin
                                        col_n = col + 1'b1;
                                        go_st = S_CHAR;
                                    end
                                end
                            endcase
                        end
                    end
                endcase
            end
        endcase

        // Next transaction's rs/data are loaded on the same edge that enters its SETUP phase.
        if (go) begin
            state_n = go_st;
            phase_n = PH_SETUP;
            cnt_n   = '0;
            rd_idx  = AW'(32'(line_n) * 32'(COLS) + 32'(col_n));
            char_n  = char_mem[rd_idx];
            base_n  = 8'(32'(line_n[0]) * 32'h40 + 32'(line_n >> 1) * 32'(COLS));
            case (go_st)
                S_FSET:  begin rs_n = 1'b0; data_n = 8'h38; end
                S_DISP:  begin rs_n = 1'b0; data_n = 8'h0C | {6'b0, cursor_on, blink_on}; end
                S_ENTRY: begin rs_n = 1'b0; data_n = 8'h06; end
                S_CLR:   begin rs_n = 1'b0; data_n = 8'h01; end
                S_ADDR:  begin rs_n = 1'b0; data_n = 8'h80 | base_n; end
                S_CHAR:  begin rs_n = 1'b1; data_n = char_n; end
                S_GAP:   fp_n = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_text_lcd_ctrl.sv
// Scoreboard bench for text_lcd_ctrl: expected strobes are queued as stimulus is set up and
// popped on every lcd_e rising edge; init timing and frame structure are checked alongside.
module tb_text_lcd_ctrl;

    localparam int COLS = 16;
    localparam int CLR_CYC = 200;
    localparam int SETUP_CYC = 1;

    logic       clk = 1'b0;
    logic       resetn;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       cursor_on, blink_on;
    logic       lcd_e, lcd_rs, lcd_rw, init_done, frame_pulse;
    logic [7:0] lcd_data;

    text_lcd_ctrl dut (
        .clk(clk), .resetn(resetn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cursor_on(cursor_on), .blink_on(blink_on),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
        .init_done(init_done), .frame_pulse(frame_pulse)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] sb_q[$];
    logic [7:0] exp_mem [32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] d);
        sb_q.push_back({rs, d});
    endtask

    task automatic push_frame();
        push(1'b0, 8'h80);
        for (int c = 0; c < COLS; c++) push(1'b1, exp_mem[c]);
        push(1'b0, 8'hC0);
        for (int c = 0; c < COLS; c++) push(1'b1, exp_mem[COLS + c]);
    endtask

    task automatic write_char(input logic [5:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_fp();
        int n = 0;
        @(negedge clk);
        while (!frame_pulse && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!frame_pulse) chk("fp_timeout", {31'b0, frame_pulse}, 1);
    endtask

    // Bus monitor: edge_cnt equals the index of the rising edge just passed since reset release.
    int edge_cnt, strobes, fp_cnt, fall_edge;
    logic prev_e, prev_fp, early_e, clr_pending, after_clr;
    logic [8:0] exp_w;

    always @(negedge clk) begin
        if (resetn) begin
            edge_cnt = 0; strobes = 0; fp_cnt = 0; fall_edge = 0;
            prev_e = 1'b0; prev_fp = 1'b0; early_e = 1'b0;
            clr_pending = 1'b0; after_clr = 1'b0;
        end else begin
            edge_cnt++;
            if (edge_cnt < 70 && lcd_e) early_e = 1'b1;
            if (edge_cnt == 70) begin
                chk("e_low_before_71", {31'b0, early_e | lcd_e}, 0);
                chk("first_cmd", {23'b0, lcd_rs, lcd_data}, 32'h038);
            end
            if (edge_cnt == 71) chk("e_rise_71", {31'b0, lcd_e}, 1);
            if (edge_cnt == 73) chk("e_fall_73", {31'b0, lcd_e}, 0);
            if (lcd_e && !prev_e) begin
                strobes++;
                chk("rw_low", {31'b0, lcd_rw}, 0);
                if (after_clr) begin
                    chk("clr_wait", edge_cnt - fall_edge, CLR_CYC + SETUP_CYC);
                    chk("init_done_hi", {31'b0, init_done}, 1);
                    after_clr = 1'b0;
                end
                if ({lcd_rs, lcd_data} == 9'h001) begin
                    chk("init_done_lo", {31'b0, init_done}, 0);
                    clr_pending = 1'b1;
                end
                if (sb_q.size() > 0) begin
                    exp_w = sb_q.pop_front();
                    chk("strobe", {23'b0, lcd_rs, lcd_data}, {23'b0, exp_w});
                end
            end
            if (!lcd_e && prev_e) begin
                fall_edge = edge_cnt;
                if (clr_pending) begin
                    after_clr   = 1'b1;
                    clr_pending = 1'b0;
                end
            end
            if (prev_fp) chk("fp_width", {31'b0, frame_pulse}, 0);
            if (frame_pulse) begin
                chk("frame_strobes", strobes, (fp_cnt == 0) ? 38 : 34);
                fp_cnt++;
                strobes = 0;
            end
            prev_e  = lcd_e;
            prev_fp = frame_pulse;
        end
    end

    initial begin
        int n;
        resetn    = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        cursor_on = 1'b1;
        blink_on  = 1'b1;
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;

        repeat (3) @(negedge clk);
        chk("rst_e_rs_rw", {29'b0, lcd_e, lcd_rs, lcd_rw}, 0);
        chk("rst_data", {24'b0, lcd_data}, 0);
        chk("rst_flags", {30'b0, init_done, frame_pulse}, 0);

        push(1'b0, 8'h38); push(1'b0, 8'h0F); push(1'b0, 8'h06); push(1'b0, 8'h01);
        exp_mem[0]  = 8'h41;
        exp_mem[31] = 8'h5A;
        push_frame();
        #2 resetn = 1'b0;

        repeat (5) @(negedge clk);
        write_char(6'd0, 8'h41);
        write_char(6'd31, 8'h5A);

        wait_fp();
        exp_mem[5] = 8'h42;
        write_char(6'd5, 8'h42);
        push_frame();
        wait_fp();
        chk("q_drain_1", sb_q.size(), 0);
        wait_fp();

        // Abort in the middle of a data strobe.
        n = 0;
        @(negedge clk);
        while (!(lcd_e && lcd_rs) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("found_char_strobe", {30'b0, lcd_e, lcd_rs}, 3);
        #1 resetn = 1'b1;
        #1;
        chk("abort_e", {31'b0, lcd_e}, 0);
        chk("abort_rs_data", {23'b0, lcd_rs, lcd_data}, 0);
        chk("abort_flags", {30'b0, init_done, frame_pulse}, 0);

        cursor_on = 1'b0;
        blink_on  = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
        push(1'b0, 8'h38); push(1'b0, 8'h0C); push(1'b0, 8'h06); push(1'b0, 8'h01);
        push_frame();
        repeat (2) @(negedge clk);
        #2 resetn = 1'b0;

        wait_fp();
        chk("q_drain_2", sb_q.size(), 0);
        wait_fp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
